// File: rtl/ir_fetch_controller.sv
// ir_fetch_controller
// Per-core instruction sequencer: fetches an instruction from instruction
// memory, loads it into the Instruction_register, decodes the opcode, hands
// it to the datapath and waits for completion before advancing the PC.
// Optional single-step mode: define IR_SINGLE_STEP_EN to add the step input
// and a PAUSE state entered after every retired instruction.
`timescale 1ns/1ps

module ir_fetch_controller #(
  parameter int unsigned         INSTR_W  = 17,
  parameter int unsigned         ADDR_W   = 8,
  parameter int unsigned         MEM_LAT  = 1,
  parameter int unsigned         OPCODE_W = 5,
  parameter logic [OPCODE_W-1:0] HALT_OP  = 5'b11111
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  output logic               imem_rd,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               ir_write,
  output logic [INSTR_W-1:0] ir_data,
  output logic               ir_clr,
  input  logic [INSTR_W-1:0] ir_q,
  output logic               exec_valid,
  input  logic               exec_done,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_addr,
`ifdef IR_SINGLE_STEP_EN
  input  logic               step,
`endif
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted,
  output logic [15:0]        instr_count
);

  // WAIT lasts MEM_LAT-1 cycles; the counter is loaded with MEM_LAT-2 on
  // entry and WAIT exits when it reaches zero.
  localparam int unsigned WAIT_INIT = (MEM_LAT > 1) ? MEM_LAT - 2 : 0;
  localparam int unsigned CNT_W     = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_DECODE,
    S_EXEC,
    S_HALT
`ifdef IR_SINGLE_STEP_EN
    , S_PAUSE
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [15:0]        count_q, count_d;
  logic [CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic               imem_rd_q, imem_rd_d;
  logic               ir_write_q, ir_write_d;
  logic               ir_clr_q, ir_clr_d;
  logic               busy_q, busy_d;
  logic               halted_q, halted_d;
  logic               is_halt;

  assign is_halt = (ir_q[INSTR_W-1 -: OPCODE_W] == HALT_OP);

  // Next-state, PC/counter updates and next values of the registered strobes.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    count_d   = count_q;
    lat_cnt_d = lat_cnt_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = start_addr;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (MEM_LAT > 1) begin
          lat_cnt_d = CNT_W'(WAIT_INIT);
          state_d   = S_WAIT;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_WAIT: begin
        if (lat_cnt_q == '0) state_d = S_LOAD;
        else                 lat_cnt_d = lat_cnt_q - CNT_W'(1);
      end
      S_LOAD:   state_d = S_DECODE;
      S_DECODE: state_d = is_halt ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (exec_done) begin
          pc_d    = jump ? jump_addr : pc_q + ADDR_W'(1);
          count_d = count_q + 16'd1;
`ifdef IR_SINGLE_STEP_EN
          state_d = S_PAUSE;
`else
          state_d = S_FETCH;
`endif
        end
      end
`ifdef IR_SINGLE_STEP_EN
      S_PAUSE: if (step) state_d = S_FETCH;
`endif
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered, so they are derived from the state being entered.
    imem_rd_d  = (state_d == S_FETCH);
    ir_write_d = (state_d == S_LOAD);
    ir_clr_d   = (state_q == S_DECODE) && is_halt;
    busy_d     = !((state_d == S_IDLE) || (state_d == S_HALT));
    halted_d   = (state_d == S_HALT);
  end

  // State and registered outputs; reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      count_q    <= '0;
      lat_cnt_q  <= '0;
      imem_rd_q  <= 1'b0;
      ir_write_q <= 1'b0;
      ir_clr_q   <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      lat_cnt_q  <= lat_cnt_d;
      imem_rd_q  <= imem_rd_d;
      ir_write_q <= ir_write_d;
      ir_clr_q   <= ir_clr_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
    end
  end

  assign imem_rd     = imem_rd_q;
  assign imem_addr   = pc_q;
  assign ir_write    = ir_write_q;
  assign ir_data     = imem_data;
  assign ir_clr      = ir_clr_q;
  assign exec_valid  = (state_q == S_DECODE) && !is_halt;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_ir_fetch_controller.sv
// Directed bench for ir_fetch_controller: instance a uses MEM_LAT=1,
// instance b uses MEM_LAT=3. Each has its own memory pipeline and
// Instruction_register model fed from a shared instruction memory image.
`timescale 1ns/1ps

module tb_ir_fetch_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [16:0] mem [256];

  // Instance a signals (MEM_LAT = 1)
  logic        start_a, imem_rd_a, ir_write_a, ir_clr_a, exec_valid_a;
  logic        exec_done_a, jump_a, busy_a, halted_a, step_a;
  logic [7:0]  start_addr_a, imem_addr_a, jump_addr_a, pc_a;
  logic [16:0] imem_data_a, ir_data_a, ir_q_a;
  logic [15:0] cnt_a;

  // Instance b signals (MEM_LAT = 3)
  logic        start_b, imem_rd_b, ir_write_b, ir_clr_b, exec_valid_b;
  logic        exec_done_b, jump_b, busy_b, halted_b, step_b;
  logic [7:0]  start_addr_b, imem_addr_b, jump_addr_b, pc_b;
  logic [16:0] imem_data_b, ir_data_b, ir_q_b;
  logic [15:0] cnt_b;
  logic [16:0] pipe_b1, pipe_b2;

  int n_assert = 0;
  int n_fail   = 0;

  ir_fetch_controller #(.MEM_LAT(1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .start_addr(start_addr_a),
    .imem_rd(imem_rd_a), .imem_addr(imem_addr_a), .imem_data(imem_data_a),
    .ir_write(ir_write_a), .ir_data(ir_data_a), .ir_clr(ir_clr_a), .ir_q(ir_q_a),
    .exec_valid(exec_valid_a), .exec_done(exec_done_a), .jump(jump_a),
    .jump_addr(jump_addr_a),
`ifdef IR_SINGLE_STEP_EN
    .step(step_a),
`endif
    .pc(pc_a), .busy(busy_a), .halted(halted_a), .instr_count(cnt_a)
  );

  ir_fetch_controller #(.MEM_LAT(3)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .start_addr(start_addr_b),
    .imem_rd(imem_rd_b), .imem_addr(imem_addr_b), .imem_data(imem_data_b),
    .ir_write(ir_write_b), .ir_data(ir_data_b), .ir_clr(ir_clr_b), .ir_q(ir_q_b),
    .exec_valid(exec_valid_b), .exec_done(exec_done_b), .jump(jump_b),
    .jump_addr(jump_addr_b),
`ifdef IR_SINGLE_STEP_EN
    .step(step_b),
`endif
    .pc(pc_b), .busy(busy_b), .halted(halted_b), .instr_count(cnt_b)
  );

  // Instruction memories: data appears MEM_LAT cycles after the read strobe.
  always_ff @(posedge clk) begin
    imem_data_a <= imem_rd_a ? mem[imem_addr_a] : 17'h0;
    pipe_b1     <= imem_rd_b ? mem[imem_addr_b] : 17'h0;
    pipe_b2     <= pipe_b1;
    imem_data_b <= pipe_b2;
  end

  // Instruction_register models: clear, else load on write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q_a <= '0;
      ir_q_b <= '0;
    end else begin
      if (ir_clr_a)        ir_q_a <= '0;
      else if (ir_write_a) ir_q_a <= ir_data_a;
      if (ir_clr_b)        ir_q_b <= '0;
      else if (ir_write_b) ir_q_b <= ir_data_b;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // After a retiring exec_done edge: in single-step builds the controller
  // parks in PAUSE until step; otherwise it is already in FETCH.
  task automatic after_done();
`ifdef IR_SINGLE_STEP_EN
    for (int i = 0; i < 5; i++) begin
      check("pause_no_rd", imem_rd_a | imem_rd_b, 1'b0);
      check("pause_busy", busy_a | busy_b, 1'b1);
      tick();
    end
    step_a = 1'b1;
    step_b = 1'b1;
    tick();
    step_a = 1'b0;
    step_b = 1'b0;
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 17'h0;
    mem[8'h10] = 17'h00124;
    mem[8'h11] = 17'h00200;
    mem[8'h40] = 17'h00300;
    mem[8'h41] = 17'h1F000;
    mem[8'h00] = 17'h00555;
    mem[8'hFF] = 17'h00ABC;

    rst = 1'b1;
    start_a = 0; start_addr_a = 0; exec_done_a = 0; jump_a = 0; jump_addr_a = 0; step_a = 0;
    start_b = 0; start_addr_b = 0; exec_done_b = 0; jump_b = 0; jump_addr_b = 0; step_b = 0;
    repeat (2) tick();

    // Reset state
    check("rst_imem_rd", imem_rd_a, 1'b0);
    check("rst_ir_write", ir_write_a, 1'b0);
    check("rst_ir_clr", ir_clr_a, 1'b0);
    check("rst_exec_valid", exec_valid_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_halted", halted_a, 1'b0);
    check("rst_pc", pc_a, 8'h00);
    check("rst_count", cnt_a, 16'h0);
    rst = 1'b0;
    tick();

    // ---- Instance a: first instruction at 0x10 ----
    start_a = 1'b1; start_addr_a = 8'h10;
    tick();                                        // FETCH
    start_a = 1'b0;
    check("a1_fetch_rd", imem_rd_a, 1'b1);
    check("a1_fetch_addr", imem_addr_a, 8'h10);
    check("a1_fetch_busy", busy_a, 1'b1);
    check("a1_fetch_no_wr", ir_write_a, 1'b0);
    exec_done_a = 1'b1;                            // must be ignored in FETCH
    tick();                                        // LOAD
    exec_done_a = 1'b0;
    check("a1_load_wr", ir_write_a, 1'b1);
    check("a1_load_data", ir_data_a, 17'h00124);
    check("a1_load_rd_off", imem_rd_a, 1'b0);
    check("a1_fetch_done_ign_pc", pc_a, 8'h10);
    check("a1_fetch_done_ign_cnt", cnt_a, 16'd0);
    tick();                                        // DECODE
    check("a1_exec_valid", exec_valid_a, 1'b1);
    check("a1_decode_no_wr", ir_write_a, 1'b0);
    tick();                                        // EXEC
    check("a1_exec_valid_pulse", exec_valid_a, 1'b0);
    check("a1_exec_busy", busy_a, 1'b1);
    exec_done_a = 1'b1;
    start_a = 1'b1; start_addr_a = 8'h77;          // start while busy: ignored
    tick();
    exec_done_a = 1'b0; start_a = 1'b0;
    check("a1_done_pc", pc_a, 8'h11);
    check("a1_done_cnt", cnt_a, 16'd1);
    after_done();
    check("a2_fetch_rd", imem_rd_a, 1'b1);
    check("a2_fetch_addr", imem_addr_a, 8'h11);

    // ---- Instance a: jump ----
    tick();                                        // LOAD
    check("a2_load_data", ir_data_a, 17'h00200);
    tick();                                        // DECODE
    check("a2_exec_valid", exec_valid_a, 1'b1);
    tick();                                        // EXEC
    jump_a = 1'b1; jump_addr_a = 8'h40;            // jump without exec_done
    tick();
    check("a2_jump_nodone_pc", pc_a, 8'h11);
    check("a2_jump_nodone_busy", busy_a, 1'b1);
    check("a2_jump_nodone_rd", imem_rd_a, 1'b0);
    exec_done_a = 1'b1;
    tick();
    exec_done_a = 1'b0; jump_a = 1'b0; jump_addr_a = 8'h99;
    check("a2_jump_pc", pc_a, 8'h40);
    check("a2_jump_cnt", cnt_a, 16'd2);
    after_done();
    check("a3_fetch_addr", imem_addr_a, 8'h40);
    check("a3_fetch_rd", imem_rd_a, 1'b1);
    tick();                                        // LOAD
    tick();                                        // DECODE
    check("a3_exec_valid", exec_valid_a, 1'b1);
    tick();                                        // EXEC
    exec_done_a = 1'b1;
    tick();
    exec_done_a = 1'b0;
    check("a3_inc_pc", pc_a, 8'h41);
    check("a3_inc_cnt", cnt_a, 16'd3);
    after_done();
    check("a4_fetch_addr", imem_addr_a, 8'h41);

    // ---- Instance a: halt ----
    tick();                                        // LOAD
    check("a4_load_data", ir_data_a, 17'h1F000);
    tick();                                        // DECODE
    check("a4_halt_no_valid", exec_valid_a, 1'b0);
    check("a4_decode_not_halted", halted_a, 1'b0);
    tick();                                        // HALT, first cycle
    check("a4_halted", halted_a, 1'b1);
    check("a4_ir_clr", ir_clr_a, 1'b1);
    check("a4_halt_busy", busy_a, 1'b0);
    check("a4_halt_pc", pc_a, 8'h41);
    check("a4_halt_cnt", cnt_a, 16'd3);
    check("a4_halt_no_valid2", exec_valid_a, 1'b0);
    tick();
    check("a4_ir_clr_one", ir_clr_a, 1'b0);
    check("a4_still_halted", halted_a, 1'b1);
    check("a4_ir_cleared", ir_q_a, 17'h0);
    start_a = 1'b1; start_addr_a = 8'h00;
    tick();                                        // FETCH
    start_a = 1'b0;
    check("a5_fetch_rd", imem_rd_a, 1'b1);
    check("a5_fetch_addr", imem_addr_a, 8'h00);
    check("a5_cnt_kept", cnt_a, 16'd3);
    check("a5_not_halted", halted_a, 1'b0);
    tick();                                        // LOAD
    check("a5_load_data", ir_data_a, 17'h00555);
    tick();                                        // DECODE
    check("a5_exec_valid", exec_valid_a, 1'b1);
    tick();                                        // EXEC

    // Asynchronous reset mid-exec
    #2 rst = 1'b1;
    #1;
    check("a_arst_busy", busy_a, 1'b0);
    check("a_arst_pc", pc_a, 8'h00);
    check("a_arst_cnt", cnt_a, 16'd0);
    check("a_arst_rd", imem_rd_a, 1'b0);
    check("a_arst_valid", exec_valid_a, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // ---- Instance b: MEM_LAT=3, PC wrap ----
    start_b = 1'b1; start_addr_b = 8'hFF;
    tick();                                        // FETCH
    start_b = 1'b0;
    check("b1_fetch_rd", imem_rd_b, 1'b1);
    check("b1_fetch_addr", imem_addr_b, 8'hFF);
    tick();                                        // WAIT 1
    check("b1_wait1_rd", imem_rd_b, 1'b0);
    check("b1_wait1_wr", ir_write_b, 1'b0);
    check("b1_wait1_busy", busy_b, 1'b1);
    tick();                                        // WAIT 2
    check("b1_wait2_wr", ir_write_b, 1'b0);
    tick();                                        // LOAD, 3 cycles after rd
    check("b1_load_wr", ir_write_b, 1'b1);
    check("b1_load_data", ir_data_b, 17'h00ABC);
    tick();                                        // DECODE
    check("b1_exec_valid", exec_valid_b, 1'b1);
    tick();                                        // EXEC
    exec_done_b = 1'b1;
    tick();
    exec_done_b = 1'b0;
    check("b1_wrap_pc", pc_b, 8'h00);
    check("b1_cnt", cnt_b, 16'd1);
    after_done();
    check("b2_fetch_rd", imem_rd_b, 1'b1);
    check("b2_fetch_addr", imem_addr_b, 8'h00);
    tick();                                        // WAIT
    check("b2_wait_busy", busy_b, 1'b1);

    // Asynchronous reset mid-WAIT
    #2 rst = 1'b1;
    #1;
    check("b_arst_busy", busy_b, 1'b0);
    check("b_arst_wr", ir_write_b, 1'b0);
    check("b_arst_rd", imem_rd_b, 1'b0);
    check("b_arst_pc", pc_b, 8'h00);
    check("b_arst_cnt", cnt_b, 16'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("b_post_rst_no_wr", ir_write_b, 1'b0);
      check("b_post_rst_idle", busy_b, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
